// File: rtl/status_flag_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : status_flag_unit_pkg
//  Description : Shared constants for the status flag unit and the
//                condition checker. This covers the flag bit positions
//                inside the packed {z,c,n,v} word and the encoding of the
//                flag-update FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package status_flag_unit_pkg;

    // Bit positions inside the packed status word {z,c,n,v}
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGS_W = 4;

    // Flag-update FSM state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

endpackage : status_flag_unit_pkg
`default_nettype wire

// File: rtl/status_flag_unit_flag_gen.sv
`default_nettype none
// ============================================================================
//  Module      : flag_gen
//  Description : Combinational computation of the {z,c,n,v} flags for the
//                instruction in EXE. Logical ops leave C and V untouched,
//                so the current committed C/V are passed in and forwarded.
//  Ports       : alu_result   - ALU result (WIDTH bits)
//                alu_carry    - ALU carry-out
//                alu_overflow - ALU signed overflow
//                arith        - 1 = arithmetic op (C,V from ALU)
//                cur_c/cur_v  - currently committed C/V
//                flags        - computed flags {z,c,n,v}
//  Revision    : 1.0 - initial release
// ============================================================================
module flag_gen
    import status_flag_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carry,
    input  logic               alu_overflow,
    input  logic               arith,
    input  logic               cur_c,
    input  logic               cur_v,
    output logic [FLAGS_W-1:0] flags
);

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (alu_result == '0);
        flags[FLAG_N] = alu_result[WIDTH-1];
        flags[FLAG_C] = arith ? alu_carry    : cur_c;
        flags[FLAG_V] = arith ? alu_overflow : cur_v;
    end

endmodule : flag_gen
`default_nettype wire

// File: rtl/status_flag_unit.sv
`default_nettype none
// ============================================================================
//  Module      : status_flag_unit
//  Description : Committed condition-flag register with freeze handling,
//                flush, and exception save/restore of the flags.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                alu_result/carry/overflow/arith - EXE-stage ALU outputs
//                s_bit, exe_valid  - flag-update request qualifiers
//                flush             - kill EXE instruction and held update
//                freeze            - stall; EXE instruction is re-presented
//                exc_save/restore  - copy flags to/from the saved register
//                status            - committed flags {z,c,n,v}
//                status_fwd        - next value of status (combinational)
//                held              - a frozen update is pending
//  Revision    : 1.0 - initial release
// ============================================================================
module status_flag_unit
    import status_flag_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carry,
    input  logic               alu_overflow,
    input  logic               arith,
    input  logic               s_bit,
    input  logic               exe_valid,
    input  logic               flush,
    input  logic               freeze,
    input  logic               exc_save,
    input  logic               exc_restore,
    output logic [FLAGS_W-1:0] status,
    output logic [FLAGS_W-1:0] status_fwd,
    output logic               held
);

    logic [0:0]         state;
    logic [0:0]         state_next;
    logic [FLAGS_W-1:0] pending;
    logic [FLAGS_W-1:0] pending_next;
    logic [FLAGS_W-1:0] saved;
    logic [FLAGS_W-1:0] computed;
    logic [FLAGS_W-1:0] status_base;   // next status ignoring a restore
    logic               req;
    logic               commit;
    logic               load_new;

    flag_gen #(
        .WIDTH        (WIDTH)
    ) u_flag_gen (
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .arith        (arith),
        .cur_c        (status[FLAG_C]),
        .cur_v        (status[FLAG_V]),
        .flags        (computed)
    );

    assign req  = exe_valid & s_bit & ~flush;
    assign held = (state == ST_HELD);

    always_comb begin
        // Leaving HELD commits the parked flags; the instruction that is
        // re-presented in that cycle is the same one, so its req is ignored.
        commit   = (state == ST_HELD) && !freeze && !flush;
        load_new = (state == ST_IDLE) && req && !freeze;

        status_base = status;
        if (commit) begin
            status_base = pending;
        end else if (load_new) begin
            status_base = computed;
        end

        // Restore wins over any update; saved still captures status_base.
        status_fwd = exc_restore ? saved : status_base;

        state_next   = state;
        pending_next = pending;
        if (flush) begin
            state_next   = ST_IDLE;
            pending_next = '0;
        end else if (state == ST_IDLE) begin
            if (req && freeze) begin
                state_next   = ST_HELD;
                pending_next = computed;
            end
        end else if (!freeze) begin
            state_next   = ST_IDLE;
            pending_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pending <= '0;
            saved   <= '0;
            status  <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            status  <= status_fwd;
            if (exc_save) begin
                saved <= status_base;
            end
        end
    end

endmodule : status_flag_unit
`default_nettype wire

// File: tb/tb_status_flag_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_status_flag_unit
//  Description : Directed self-checking bench for status_flag_unit. Each
//                clocked step pushes the expected status/held into a
//                scoreboard queue; the values are popped and compared one
//                cycle later, after the active edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_status_flag_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_overflow;
    logic             arith;
    logic             s_bit;
    logic             exe_valid;
    logic             flush;
    logic             freeze;
    logic             exc_save;
    logic             exc_restore;
    logic [3:0]       status;
    logic [3:0]       status_fwd;
    logic             held;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic       hd;
    } exp_t;

    exp_t exp_q[$];

    status_flag_unit #(
        .WIDTH        (WIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .arith        (arith),
        .s_bit        (s_bit),
        .exe_valid    (exe_valid),
        .flush        (flush),
        .freeze       (freeze),
        .exc_save     (exc_save),
        .exc_restore  (exc_restore),
        .status       (status),
        .status_fwd   (status_fwd),
        .held         (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive ALU-side inputs for one instruction
    task automatic alu(input logic [WIDTH-1:0] res, input logic ar,
                       input logic cy, input logic ov);
        alu_result   = res;
        arith        = ar;
        alu_carry    = cy;
        alu_overflow = ov;
    endtask

    // Push expectation, advance one edge, pop and compare
    task automatic tick(input string tag, input logic [3:0] st, input logic hd);
        exp_t e;
        exp_q.push_back('{tag, st, hd});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, "_status"}, status, e.st);
        chk({e.tag, "_held"}, {3'b000, held}, {3'b000, e.hd});
    endtask

    task automatic fwd(input string tag, input logic [3:0] exp);
        #1;
        chk({tag, "_fwd"}, status_fwd, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        alu(32'h0, 1'b0, 1'b0, 1'b0);
        s_bit = 0; exe_valid = 0; flush = 0; freeze = 0;
        exc_save = 0; exc_restore = 0;

        // Reset state
        #2;
        chk("reset_status", status, 4'b0000);
        chk("reset_held", {3'b000, held}, 4'b0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick("idle_after_reset", 4'b0000, 1'b0);

        // Zero result with carry: Z,C set, visible on fwd same cycle
        alu(32'h0, 1'b1, 1'b1, 1'b0); s_bit = 1; exe_valid = 1;
        fwd("zero_carry", 4'b1100);
        tick("zero_carry", 4'b1100, 1'b0);

        // No request -> hold
        s_bit = 0;
        fwd("no_req", 4'b1100);
        tick("no_req", 4'b1100, 1'b0);

        // Negative with overflow
        alu(32'hFFFF_FFF0, 1'b1, 1'b0, 1'b1); s_bit = 1;
        tick("neg_ovf", 4'b0011, 1'b0);

        // Reach 0101 then logical op keeps C,V
        alu(32'h1, 1'b1, 1'b1, 1'b1);
        tick("set_0101", 4'b0101, 1'b0);
        alu(32'h8000_0000, 1'b0, 1'b0, 1'b0);
        fwd("logical_keep_cv", 4'b0111);
        tick("logical_keep_cv", 4'b0111, 1'b0);

        // Invalid slot does not update
        exe_valid = 0; alu(32'h0, 1'b1, 1'b0, 1'b0);
        tick("not_valid", 4'b0111, 1'b0);

        // Freeze for three cycles, inputs changed while held
        exe_valid = 1; freeze = 1; alu(32'h0, 1'b1, 1'b0, 1'b0);
        fwd("freeze_enter", 4'b0111);
        tick("freeze_c1", 4'b0111, 1'b1);
        alu(32'h5, 1'b1, 1'b1, 1'b1);
        fwd("freeze_hold", 4'b0111);
        tick("freeze_c2", 4'b0111, 1'b1);
        tick("freeze_c3", 4'b0111, 1'b1);
        freeze = 0;
        fwd("freeze_commit", 4'b1000);
        tick("freeze_commit", 4'b1000, 1'b0);
        s_bit = 0;
        tick("after_commit", 4'b1000, 1'b0);

        // HELD then flush drops the pending update
        s_bit = 1; freeze = 1; alu(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        tick("held_for_flush", 4'b1000, 1'b1);
        flush = 1; freeze = 0;
        fwd("flush_held", 4'b1000);
        tick("flush_held", 4'b1000, 1'b0);
        flush = 0; s_bit = 0;
        tick("flush_no_commit", 4'b1000, 1'b0);
        s_bit = 1; flush = 1;
        fwd("flush_idle", 4'b1000);
        tick("flush_idle", 4'b1000, 1'b0);
        flush = 0; s_bit = 0;

        // Save 1000, update to 0010, restore with simultaneous req
        exc_save = 1;
        tick("save", 4'b1000, 1'b0);
        exc_save = 0; s_bit = 1; alu(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        tick("update_0010", 4'b0010, 1'b0);
        exc_restore = 1; alu(32'h0, 1'b1, 1'b1, 1'b0);
        fwd("restore_req", 4'b1000);
        tick("restore_req", 4'b1000, 1'b0);
        exc_restore = 0;

        // Save and restore together: status gets old saved, saved gets update
        alu(32'hFFFF_FFF0, 1'b1, 1'b0, 1'b1);
        tick("update_0011", 4'b0011, 1'b0);
        exc_save = 1; exc_restore = 1; alu(32'h1, 1'b1, 1'b1, 1'b0);
        fwd("save_restore", 4'b1000);
        tick("save_restore", 4'b1000, 1'b0);
        exc_save = 0; s_bit = 0;
        fwd("restore_new_saved", 4'b0100);
        tick("restore_new_saved", 4'b0100, 1'b0);
        exc_restore = 0;

        // Async reset mid-cycle while HELD
        s_bit = 1; freeze = 1; alu(32'h0, 1'b1, 1'b1, 1'b1);
        tick("held_for_reset", 4'b0100, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_status", status, 4'b0000);
        chk("async_rst_held", {3'b000, held}, 4'b0000);
        s_bit = 0; freeze = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick("post_reset_idle", 4'b0000, 1'b0);
        tick("post_reset_hold", 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_status_flag_unit
`default_nettype wire

// File: doc/status_flag_unit.md
STATUS_FLAG_UNIT -- requirements
Module: status_flag_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, ALU result width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous reset, active-low.
REQ-004 SHALL have port alu_result  input  WIDTH  EXE-stage ALU result.
REQ-005 SHALL have port alu_carry  input  1  ALU carry-out.
REQ-006 SHALL have port alu_overflow  input  1  ALU signed overflow.
REQ-007 SHALL have port arith  input  1  1 = arithmetic op (updates C,V); 0 = logical op.
REQ-008 SHALL have port s_bit  input  1  instruction requests flag update.
REQ-009 SHALL have port exe_valid  input  1  EXE stage holds a real instruction.
REQ-010 SHALL have port flush  input  1  kill the EXE instruction and any held update.
REQ-011 SHALL have port freeze  input  1  pipeline stall; the EXE instruction is re-presented.
REQ-012 SHALL have port exc_save  input  1  copy the flags into the saved register.
REQ-013 SHALL have port exc_restore  input  1  reload the flags from the saved register.
REQ-014 SHALL have port status  output  4  committed flags packed {z,c,n,v}.
REQ-015 SHALL have port status_fwd  output  4  combinational next value of status, packed {z,c,n,v}.
REQ-016 SHALL have port held  output  1  a frozen update is pending.

Function
REQ-017 Computed flags SHALL be: n = alu_result[WIDTH-1]; z = (alu_result == 0); c, v = alu_carry, alu_overflow when arith=1, else current status c, v.
REQ-018 Request req SHALL be exe_valid & s_bit & ~flush.
REQ-019 The FSM SHALL have two states, IDLE and HELD; held SHALL be 1 only in HELD.
REQ-020 In IDLE with req=1 and freeze=0, status SHALL take the computed flags at the next edge (1-cycle latency).
REQ-021 In IDLE with req=1 and freeze=1, the computed flags SHALL go to pending, the state SHALL go to HELD, and status SHALL be unchanged.
REQ-022 In HELD with freeze=1, all ALU inputs SHALL be ignored and pending SHALL be held.
REQ-023 In HELD with freeze=0 and flush=0, status SHALL take pending at the edge, the state SHALL return to IDLE, and that cycle's req SHALL be ignored (it is the same instruction).
REQ-024 Flush in any state SHALL discard pending, force IDLE and block the update; exc_save/exc_restore SHALL still act.
REQ-025 Priority at an edge SHALL be: exc_restore > commit of pending > new req.
REQ-026 exc_save SHALL load saved with status_fwd (post-update value); when exc_save and exc_restore are both set, status SHALL take the old saved and saved SHALL take status_fwd computed without the restore.
REQ-027 status_fwd SHALL equal the value status takes at the next edge, with no added register, so a dependent condition check sees the new flags the same cycle.
REQ-028 With req=0, no restore and no commit, status SHALL hold.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear status, saved and pending to 4'b0000, set the state to IDLE and held to 0.
REQ-030 Reset mid-HELD SHALL drop the pending update; after release, status SHALL be 0000 until the first qualifying edge.

Structure
REQ-031 Flag bit positions (Z=3, C=2, N=1, V=0) and FSM state encodings SHALL live in the shared constants file used by the condition checker.
REQ-032 Flag computation SHALL be one combinational sub-module, flag_gen; registers and FSM stay in status_flag_unit.

Verification
REQ-033 SHALL check: result=0, arith=1, carry=1, ovf=0, s_bit=1, valid=1 -> status=4'b1100 next cycle, status_fwd=4'b1100 same cycle.
REQ-034 SHALL check: status=4'b0101, logical op, result=32'h8000_0000 -> status=4'b0111 (C,V kept).
REQ-035 SHALL check: req with freeze=1 for 3 cycles -> status unchanged, held=1; freeze drops -> status updates once, held=0.
REQ-036 SHALL check: HELD then flush=1 -> held=0, status unchanged; s_bit=1 with flush=1 in IDLE -> no update.
REQ-037 SHALL check: status=4'b1000, exc_save -> saved=1000; update to 0010; exc_restore plus a simultaneous req -> status=1000.
REQ-038 SHALL check: rst_n low asynchronously mid-clock while HELD -> status=0000 and held=0 immediately.
